// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared types and GF(2^8) helpers for the AES sub-word engine.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Request modes as seen on in_mode
    typedef enum logic [1:0] {
        AES_MODE_FWD     = 2'b00,
        AES_MODE_INV     = 2'b01,
        AES_MODE_ROT_FWD = 2'b10,
        AES_MODE_RSVD    = 2'b11
    } aes_mode_t;

    // Engine control states
    typedef enum logic [1:0] {
        SW_IDLE = 2'b00,
        SW_CALC = 2'b01,
        SW_HOLD = 2'b10
    } aes_sw_state_t;

    localparam logic [7:0] C_AFFINE_FWD = 8'h63;
    localparam logic [7:0] C_AFFINE_INV = 8'h05;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] aes_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply
    function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = aes_xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 for free)
    function automatic logic [7:0] aes_gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h01;
        pw  = x;
        for (int i = 1; i < 8; i++) begin
            pw  = aes_gf_mul(pw, pw);
            acc = aes_gf_mul(acc, pw);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aes_rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_affine_fwd(input logic [7:0] b);
        return b ^ aes_rotl8(b, 1) ^ aes_rotl8(b, 2) ^ aes_rotl8(b, 3)
                 ^ aes_rotl8(b, 4) ^ C_AFFINE_FWD;
    endfunction

    function automatic logic [7:0] aes_affine_inv(input logic [7:0] b);
        return aes_rotl8(b, 1) ^ aes_rotl8(b, 3) ^ aes_rotl8(b, 6) ^ C_AFFINE_INV;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_fwd.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_fwd
// Brief    : Forward AES S-box (GF inverse followed by the affine map).
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_fwd
    import aes_pkg::*;
(
    input  logic [7:0] in,
    output logic [7:0] out
);
    assign out = aes_affine_fwd(aes_gf_inv(in));
endmodule
`default_nettype wire

// File: rtl/aes_sbox_inv.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_inv
// Brief    : Inverse AES S-box (inverse affine map followed by GF inverse).
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_inv
    import aes_pkg::*;
(
    input  logic [7:0] in,
    output logic [7:0] out
);
    assign out = aes_gf_inv(aes_affine_inv(in));
endmodule
`default_nettype wire

// File: rtl/sbox_dual.sv
`default_nettype none
// ============================================================================
// Module   : sbox_dual
// Brief    : One forward plus one inverse S-box with a direction select.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_dual (
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);
    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    aes_sbox_fwd u_fwd (.in(in), .out(w_fwd));
    aes_sbox_inv u_inv (.in(in), .out(w_inv));

    assign out = inv ? w_inv : w_fwd;
endmodule
`default_nettype wire

// File: rtl/aes_subword_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_subword_engine
// Brief    : Time-multiplexed byte substitution over a LANES-byte word using
//            SBOX_PER_CYCLE S-box pairs per cycle; valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module aes_subword_engine
    import aes_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int SBOX_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_err,
    output logic                 busy
);
    localparam int W  = 8 * LANES;
    localparam int GW = 8 * SBOX_PER_CYCLE;
    localparam int G  = LANES / SBOX_PER_CYCLE;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(G - 1);

    if (LANES % SBOX_PER_CYCLE != 0) begin : g_bad_param
        $error("SBOX_PER_CYCLE must divide LANES");
    end

    aes_sw_state_t   r_state;
    aes_sw_state_t   w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_work;
    aes_mode_t       r_mode;
    logic [GW-1:0]   w_grp;
    logic [GW-1:0]   w_sub;
    logic            w_inv;
    logic            w_accept;

    assign w_accept  = in_valid & in_ready;
    assign w_inv     = (r_mode == AES_MODE_INV);
    assign out_valid = (r_state == SW_HOLD);
    assign out_data  = r_work;
    assign out_err   = (r_mode == AES_MODE_RSVD);
    assign busy      = (r_state != SW_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SW_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and in_ready; in_ready depends on state and out_ready only
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            SW_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = SW_CALC;
            end
            SW_CALC: begin
                if (r_cnt == C_LAST) w_state_nxt = SW_HOLD;
            end
            SW_HOLD: begin
                in_ready = out_ready;
                if (out_ready) w_state_nxt = in_valid ? SW_CALC : SW_IDLE;
            end
            default: w_state_nxt = SW_IDLE;
        endcase
    end

    // Pick the byte group addressed by the group counter
    always_comb begin
        w_grp = '0;
        for (int g = 0; g < G; g++) begin
            if (r_cnt == CW'(g)) w_grp = r_work[W-1-GW*g -: GW];
        end
    end

    for (genvar k = 0; k < SBOX_PER_CYCLE; k++) begin : g_sbox
        sbox_dual u_sbox (
            .in  (w_grp[GW-1-8*k -: 8]),
            .inv (w_inv),
            .out (w_sub[GW-1-8*k -: 8])
        );
    end

    // Latch the request (rotating for key expansion), then substitute one group per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_mode <= AES_MODE_FWD;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_mode <= aes_mode_t'(in_mode);
            if (aes_mode_t'(in_mode) == AES_MODE_ROT_FWD)
                r_work <= {in_data[W-9:0], in_data[W-1 -: 8]};
            else
                r_work <= in_data;
        end else if (r_state == SW_CALC) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
            // Reserved mode runs the same schedule but leaves the word untouched
            if (r_mode != AES_MODE_RSVD) begin
                for (int g = 0; g < G; g++) begin
                    if (r_cnt == CW'(g)) r_work[W-1-GW*g -: GW] <= w_sub;
                end
            end
        end
    end

endmodule
`default_nettype wire
